// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and slice width
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/FourBitAdder.sv
// FourBitAdder: 4-bit ripple slice with carry in/out
module FourBitAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide add sequenced one nibble per clock through a FourBitAdder
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_t state;
  logic [IW-1:0] idx;
  logic carry_r;
  logic [W-1:0] a_r, b_r;
  logic [NIBBLE_W-1:0] slice_sum;
  logic slice_cout;
  FourBitAdder u_add (
    .a   (a_r[NIBBLE_W*idx +: NIBBLE_W]),
    .b   (b_r[NIBBLE_W*idx +: NIBBLE_W]),
    .cin (carry_r),
    .sum (slice_sum),
    .cout(slice_cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_r     <= a;
          b_r     <= b;
          carry_r <= cin;
          idx     <= '0;
          busy    <= 1'b1;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
          carry_r <= slice_cout;
          if (idx == LAST) begin
            cout  <= slice_cout;
            done  <= 1'b1;
            state <= ST_DONE;
          end else idx <= idx + 1'b1;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors plus start-hold and mid-run reset sequences
module tb_nibble_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic busy, done, cout;
  int total = 0, bad = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                    input logic [15:0] es, input logic ec);
    int n = 0, nb = 0;
    bit seen = 0;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) seen = 1;
    end
    chk("done_latency", n, seen ? 5 : 99);
    chk("busy_cycles", nb, 5);
    chk("sum", sum, es);
    chk("cout", cout, ec);
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b00);
  endtask

  initial begin
    vec_t v[6];
    int t1, t2, cyc;
    logic [15:0] r1, r2;
    v[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};
    v[1] = '{16'hAAAA, 16'hBBBB, 1'b1, 16'h6666, 1'b1};
    v[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    v[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    v[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    v[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    #12;
    chk("reset_outs", {busy, done, cout, sum}, 19'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {busy, done}, 2'b00);

    for (int i = 0; i < 6; i++) op(v[i].a, v[i].b, v[i].cin, v[i].s, v[i].c);

    // start held high: second accept only after an IDLE edge, done pulses 6 apart
    r1 = 16'h3C5A; r2 = 16'h9E17;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = r1; b = r2; cin = 1'b1;
    cyc = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done && t1 < 0) begin
        t1 = cyc;
        chk("hold_sum1", {cout, sum}, 17'h03333);
      end else if (done) begin
        t2 = cyc;
        chk("hold_sum2", {cout, sum}, {1'b0, r1} + {1'b0, r2} + 17'd1);
      end
      if (t1 > 0 && cyc == t1 + 1) chk("hold_idle_gap", {busy, done}, 2'b00);
    end
    chk("hold_first_done", t1, 5);
    chk("hold_spacing", t2 - t1, 6);
    start = 1'b0;
    @(negedge clk);

    // reset two RUN edges into an operation
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_async", {busy, done, cout, sum}, 19'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    chk("abort_no_done", cyc, 0);
    chk("abort_outs", {cout, sum}, 17'h0);
    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-word adder sequencer that sits directly upstream and downstream of the existing FourBitAdder. It accepts two wide operands and a carry-in on a start pulse. It then drives the 4-bit adder one nibble per clock, least-significant nibble first, and feeds the adder's cout back through a carry register into the next nibble's cin. It collects each sum nibble into a result register and signals completion with a one-cycle done pulse.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk    input   1   system clock, rising edge
rst_n  input   1   reset, asynchronous, active-low
start  input   1   request; sampled only in IDLE
a      input   W   operand A; captured on accepted start
b      input   W   operand B; captured on accepted start
cin    input   1   carry-in to nibble 0; captured on accepted start
busy   output  1   high in RUN and DONE
done   output  1   one-cycle pulse; result valid
sum    output  W   result register
cout   output  1   carry-out of the top nibble

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n is asynchronous and active-low. While it is low, every register clears: state=IDLE, idx=0, carry_r=0, a_r=0, b_r=0, sum=0, cout=0, done=0, busy=0.
  - Deassertion of rst_n takes effect at the next rising clk edge.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at a rising edge is an accepted start.
  - On an accepted start: a_r<=a, b_r<=b, carry_r<=cin, idx<=0, state<=RUN.
  - sum and cout keep the previous result and are not cleared on start.
- RUN, at each edge:
  - The FourBitAdder sees a_r[4*idx+:4], b_r[4*idx+:4] and carry_r.
  - sum[4*idx+:4] <= adder sum; carry_r <= adder cout.
  - If idx==NIBBLES-1: cout<=adder cout, done<=1, state<=DONE. Otherwise idx<=idx+1.
- DONE:
  - Lasts exactly one cycle with done=1.
  - At the next edge: done<=0, state<=IDLE.
- start outside IDLE is ignored, including in DONE; no queueing. The first accepted start after completion needs an IDLE cycle.
- Latency:
  - Accepted start at edge E.
  - Nibble k is written at edge E+1+k.
  - done is high during the cycle after edge E+NIBBLES.
  - Throughput is one operation per NIBBLES+2 cycles.
- Output validity:
  - During RUN, sum is partially updated and not valid.
  - sum and cout are valid from the done cycle until the next accepted start's first RUN edge.
- Arithmetic:
  - {cout,sum} = a + b + cin, exact, modulo 2^(W+1).
  - No overflow flag.
- Operand changes: a, b and cin may change freely after acceptance; only the captured copies are used.
- NIBBLES=1: RUN lasts one cycle; behaviour reduces to a registered FourBitAdder with 2-cycle latency to done.
- Reset during RUN or DONE: the operation is aborted, done is never asserted, and sum and cout read 0.
- idx width is clog2(NIBBLES), minimum 1 bit. idx never exceeds NIBBLES-1.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIBBLE_W=4.
- Sub-module: one instance of the existing FourBitAdder as the datapath slice. No new sub-module.
- FSM, index counter, operand registers and result register stay in nibble_serial_adder.

Test Plan:
- NIBBLES=4, a=16'h0001, b=16'h0002, cin=0, start for one cycle -> done exactly 5 cycles after start edge (one pulse), sum=16'h0003, cout=0, busy high 5 cycles.
- a=16'hAAAA, b=16'hBBBB, cin=1 -> sum=16'h6666, cout=1.
- Full carry ripple across all nibbles: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
- Carry across a nibble boundary only: a=16'h0F0F, b=16'h00F1, cin=0 -> sum=16'h1000, cout=0.
- Start held high continuously from IDLE, with a/b changed to random values after acceptance -> the result matches the captured operands. start in RUN/DONE is not accepted. The next operation begins only after one IDLE edge, and done pulses are NIBBLES+2 cycles apart.
- Mid-operation reset: start with a=16'h1234, b=16'h4321, assert rst_n=0 between edges after 2 RUN edges -> outputs go to 0 immediately (asynchronously), with no done. After release: idle, busy=0. A new start 16'h1234+16'h4321 then gives 16'h5555, cout=0.
